seg7_scan_driver: RTL
=====================

// Module: seg7_scan_driver
// PURPOSE
//  Downstream consumer of the 28-bit DECODE1 PIO out_port: four packed 7-segment patterns.
//  Time-multiplexes them onto one shared segment bus plus four digit enables.
//  Latches a tear-free frame snapshot and inserts anti-ghosting blank gaps between digits.
//  Emits a once-per-frame tick for software or a test bench.
// PARAMETERS
//  DWELL_CYCLES    50000  clocks each digit is shown; legal 1..65535 (50 MHz -> 1 ms)
//  BLANK_CYCLES    500    clocks all-off before each digit; legal 0..65535; 0 skips BLANK
//  SEG_ACTIVE_LOW  1      1: segment lit = 0 (common anode); 0: lit = 1
//  DIG_ACTIVE_LOW  1      1: digit enabled = 0; 0: enabled = 1
// PORTS
//  clk         in   1   system clock; single clock domain
//  reset_n     in   1   asynchronous, active-low reset
//  enable      in   1   1 = scan; 0 = all outputs inactive
//  seg_data    in   28  digit i pattern = seg_data[7i+6:7i]; bit0..6 = seg a..g, 1 = lit
//  seg_out     out  7   shared segment bus, polarity set by SEG_ACTIVE_LOW
//  dig_out     out  4   one-hot digit enable, polarity set by DIG_ACTIVE_LOW; bit i = digit i
//  frame_tick  out  1   1-cycle pulse at every frame snapshot reload
// BEHAVIOUR
//  - All outputs registered. Reset values: seg_out and dig_out inactive (7'h7F / 4'hF at
//    default polarity); frame_tick = 0; state IDLE; digit index 0; counters 0; shadow = 0.
//  - FSM states: IDLE, BLANK, SHOW. 16-bit down-counter cnt; 2-bit digit index dig.
//  - IDLE, enable=1 sampled at edge:
//    - snapshot <= seg_data; dig <= 0; frame_tick pulses.
//    - Next state BLANK, cnt = BLANK_CYCLES-1; or SHOW, cnt = DWELL_CYCLES-1 if BLANK_CYCLES == 0.
//  - BLANK: seg_out and dig_out inactive. At cnt == 0: SHOW, cnt <= DWELL_CYCLES-1.
//  - SHOW: dig_out drives digit dig; seg_out = snapshot[7*dig+:7], polarity applied.
//    At cnt == 0:
//    - dig <= dig+1, wrapping 3 -> 0; go to BLANK, or SHOW if BLANK_CYCLES == 0.
//    - On wrap 3 -> 0: snapshot <= seg_data and frame_tick = 1 on that same edge.
//  - Frame period = 4*(BLANK_CYCLES+DWELL_CYCLES) clocks. frame_tick period is identical.
//  - seg_data changes mid-frame are invisible until the next wrap. No tearing.
//  - enable=0 in any state: IDLE at next edge; outputs inactive from that edge; frame_tick 0.
//    Re-enabling always restarts at digit 0 with a fresh snapshot.
//  - Never more than one digit active. seg_out is inactive whenever no digit is active.
//  - reset_n low mid-scan: outputs go inactive immediately (asynchronous). State reverts to IDLE.
// CONFIGURATION
//  SEG7_SCAN_DIM_EN defined:
//  - Adds input port dim [3:0], sampled into a register at each snapshot load.
//  - 4-bit pwm counter clears on SHOW entry and increments each SHOW cycle, wrapping.
//  - Digit and segments are active only while pwm <= dim_reg; inactive otherwise.
//  - dim=15 gives full brightness; dim=0 gives 1/16 duty.
//  SEG7_SCAN_DIM_EN undefined:
//  - No dim port and no pwm logic; SHOW is always fully on.
// TESTING  (DWELL_CYCLES=8, BLANK_CYCLES=2, default polarity unless noted)
//  1 Reset: reset_n=0 -> seg_out=7'h7F, dig_out=4'hF, frame_tick=0, held while low.
//  2 enable=1, seg_data={7'h01,7'h02,7'h04,7'h08}: 2 blank clocks.
//    Then dig_out=4'hE with seg_out=7'h77 for 8 clocks; then 4'hD/7'h7B, 4'hB/7'h7D, 4'h7/7'h7E.
//    frame_tick exactly every 40 clocks.
//  3 Change seg_data to 28'h0 during digit 1 -> digits 1..3 keep old patterns.
//    Next frame shows seg_out=7'h7F on every digit.
//  4 Drop enable during SHOW of digit 2 -> all outputs inactive next edge.
//    Re-enable -> 2 blank clocks, then digit 0 (dig_out=4'hE).
//  5 Assert reset_n=0 mid-SHOW, asynchronously -> outputs inactive same cycle.
//    After release with enable=1 -> scan restarts at digit 0.
//  6 SEG7_SCAN_DIM_EN, DWELL_CYCLES=16, dim=3 -> each digit active 4 clocks, then off 12 clocks, per dwell.
//    dim=15 -> on all 16 clocks.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexes four packed 7-segment patterns onto one segment bus.
//
// A snapshot of seg_data is taken at every frame start, so the display never tears.
// Each digit gets a short all-off gap before it is lit, which stops ghosting between digits.
// frame_tick pulses once per frame.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   enable      1 = scan, 0 = all outputs inactive
//   seg_data    digit i pattern = seg_data[7i+6:7i]; bit0..6 = seg a..g; 1 = lit
//   dim         (SEG7_SCAN_DIM_EN only) per-frame brightness; 15 = full, 0 = 1/16 duty
//   seg_out     shared segment bus, polarity set by SEG_ACTIVE_LOW
//   dig_out     one-hot digit enable, polarity set by DIG_ACTIVE_LOW
//   frame_tick  1-cycle pulse at every snapshot reload
//
// Optional feature: define SEG7_SCAN_DIM_EN to add the dim port and the PWM dimming.
module seg7_scan_driver #(
    parameter int unsigned DWELL_CYCLES   = 50000,
    parameter int unsigned BLANK_CYCLES   = 500,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [27:0] seg_data,
`ifdef SEG7_SCAN_DIM_EN
    input  logic [3:0]  dim,
`endif
    output logic [6:0]  seg_out,
    output logic [3:0]  dig_out,
    output logic        frame_tick
);
    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
    localparam logic [6:0]  SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0]  DIG_OFF    = DIG_ACTIVE_LOW ? 4'hF : 4'h0;
    localparam logic [15:0] DWELL_LOAD = 16'(DWELL_CYCLES - 1);
    localparam logic [15:0] BLANK_LOAD = BLANK_CYCLES == 0 ? 16'd0 : 16'(BLANK_CYCLES - 1);
    // Every digit slot starts with a blank gap unless the gap is configured away.
    localparam state_t      SLOT_STATE = BLANK_CYCLES == 0 ? SHOW : BLANK;
    localparam logic [15:0] SLOT_LOAD  = BLANK_CYCLES == 0 ? DWELL_LOAD : BLANK_LOAD;
    state_t          state, state_nx;
    logic [15:0]     cnt, cnt_nx;
    logic [1:0]      dig, dig_nx;
    logic [3:0][6:0] snap, snap_nx;
    logic            load;
    logic            lit;
    logic [6:0]      seg_nx;
    logic [3:0]      dig_out_nx;
    logic            tick_nx;
`ifdef SEG7_SCAN_DIM_EN
    logic [3:0] dim_reg, dim_nx, pwm, pwm_nx;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dim_reg <= 4'd0;
            pwm     <= 4'd0;
        end else begin
            dim_reg <= dim_nx;
            pwm     <= pwm_nx;
        end
    end
    // The PWM phase restarts on every entry into SHOW, including SHOW-to-SHOW digit steps.
    always_comb begin
        dim_nx = load ? dim : dim_reg;
        pwm_nx = state_nx != SHOW ? pwm : (state != SHOW || cnt == 16'd0) ? 4'd0 : pwm + 4'd1;
        lit    = pwm_nx <= dim_nx;
    end
`else
    assign lit = 1'b1;
`endif
    // State register; outputs are registered alongside it, computed from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= 16'd0;
            dig        <= 2'd0;
            snap       <= '0;
            seg_out    <= SEG_OFF;
            dig_out    <= DIG_OFF;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            dig        <= dig_nx;
            snap       <= snap_nx;
            seg_out    <= seg_nx;
            dig_out    <= dig_out_nx;
            frame_tick <= tick_nx;
        end
    end
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        dig_nx   = dig;
        load     = 1'b0;
        if (!enable) begin
            state_nx = IDLE;
            cnt_nx   = 16'd0;
            dig_nx   = 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    load     = 1'b1;
                    dig_nx   = 2'd0;
                    state_nx = SLOT_STATE;
                    cnt_nx   = SLOT_LOAD;
                end
                BLANK: begin
                    state_nx = cnt == 16'd0 ? SHOW : BLANK;
                    cnt_nx   = cnt == 16'd0 ? DWELL_LOAD : cnt - 16'd1;
                end
                SHOW: begin
                    if (cnt == 16'd0) begin
                        dig_nx   = dig + 2'd1;
                        load     = dig == 2'd3;
                        state_nx = SLOT_STATE;
                        cnt_nx   = SLOT_LOAD;
                    end else begin
                        cnt_nx = cnt - 16'd1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
        snap_nx = load ? seg_data : snap;
    end
    // Output comb: only SHOW lights anything, so segments are dark whenever no digit is on.
    always_comb begin
        tick_nx    = load;
        seg_nx     = state_nx == SHOW && lit ? snap_nx[dig_nx] ^ {7{SEG_ACTIVE_LOW}} : SEG_OFF;
        dig_out_nx = state_nx == SHOW && lit ? (4'b0001 << dig_nx) ^ {4{DIG_ACTIVE_LOW}} : DIG_OFF;
    end
endmodule
